// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pll_seq_pkg
// Purpose : Shared types and constants for the PLL lock sequencer.
//           - seq_state_t : sequencer states
//           - LOSS_CNT_W  : width of the lock-loss counter
//           - RETRY_W     : width of the retry counter
//           - max_int     : elaboration-time helper for counter sizing
// Revision: 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } seq_state_t;

    localparam int LOSS_CNT_W = 8;
    localparam int RETRY_W    = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_2ff
// Purpose : Two-flop synchronizer for asynchronous level signals.
// Ports   : clk  - destination clock
//           rst  - synchronous active-high reset, clears both stages
//           i_d  - asynchronous input
//           o_q  - synchronized output (two clk cycles of latency)
// Revision: 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pll_lock_sequencer
// Purpose : Board-clock-domain controller for the iCE40 PLL. Pulses the PLL
//           RESETB pin, waits for a synchronized and stable LOCK, then holds
//           the core reset a little longer before releasing it. Retries on
//           lock timeout, parks in a sticky FAULT after too many retries and
//           re-sequences on lock loss or host request.
// Ports   : clk_i        - 12 MHz board clock
//           reset_i      - synchronous active-high reset
//           locked_i     - PLL LOCK (asynchronous)
//           relock_req_i - restart pulse, honoured in RUN or FAULT only
//           pll_resetb_o - PLL RESETB, active-low
//           sys_reset_o  - active-high reset for the PLL-clocked core
//           ready_o      - high in RUN
//           fault_o      - high in FAULT
//           lock_lost_o  - one-cycle pulse on lock loss in RUN
//           retries_o    - retries used in the current acquisition
//           loss_count_o - saturating count of lock losses in RUN
// Revision: 1.0 - initial release
// ============================================================================
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 12000,
    parameter int LOCK_STABLE_CYCLES  = 1200,
    parameter int RESET_HOLD_CYCLES   = 64,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  locked_i,
    input  logic                  relock_req_i,
    output logic                  pll_resetb_o,
    output logic                  sys_reset_o,
    output logic                  ready_o,
    output logic                  fault_o,
    output logic                  lock_lost_o,
    output logic [RETRY_W-1:0]    retries_o,
    output logic [LOSS_CNT_W-1:0] loss_count_o
);

    localparam int c_cnt_max = max_int(max_int(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES),
                                       max_int(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES));
    localparam int c_cnt_w   = $clog2(c_cnt_max) + 1;

    localparam logic [c_cnt_w-1:0] c_prst_last    = c_cnt_w'(PLL_RESET_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last  = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last    = c_cnt_w'(RESET_HOLD_CYCLES - 1);
    localparam logic [RETRY_W-1:0] c_max_retries  = RETRY_W'(MAX_RETRIES);

    seq_state_t            r_state;
    seq_state_t            w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_cnt_w-1:0]    w_cnt_nxt;
    logic [RETRY_W-1:0]    r_retries;
    logic [RETRY_W-1:0]    w_retries_nxt;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;
    logic [LOSS_CNT_W-1:0] w_loss_cnt_nxt;
    logic                  r_lock_lost;
    logic                  w_lock_lost_nxt;
    logic                  w_lock_s;

    // locked_i is used nowhere else: everything below sees only w_lock_s.
    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (clk_i),
        .rst (reset_i),
        .i_d (locked_i),
        .o_q (w_lock_s)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_retries_nxt   = r_retries;
        w_loss_cnt_nxt  = r_loss_cnt;
        w_lock_lost_nxt = 1'b0;

        case (r_state)
            PLL_RESET: begin
                if (r_cnt == c_prst_last) begin
                    w_state_nxt = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // A lock seen on the final timeout cycle still wins.
                if (w_lock_s) begin
                    w_state_nxt = STABLE;
                end else if (r_cnt == c_timeout_last) begin
                    if (r_retries == c_max_retries) begin
                        w_state_nxt = FAULT;
                    end else begin
                        w_retries_nxt = r_retries + RETRY_W'(1);
                        w_state_nxt   = PLL_RESET;
                    end
                end
            end
            STABLE: begin
                // A glitch restarts the timeout window without costing a retry.
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_cnt == c_stable_last) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!w_lock_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_cnt == c_hold_last) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // Lock loss takes precedence; a simultaneous relock request
                // would lead to the same place anyway.
                if (!w_lock_s) begin
                    w_lock_lost_nxt = 1'b1;
                    if (r_loss_cnt != '1) begin
                        w_loss_cnt_nxt = r_loss_cnt + LOSS_CNT_W'(1);
                    end
                    w_retries_nxt = '0;
                    w_state_nxt   = PLL_RESET;
                end else if (relock_req_i) begin
                    w_retries_nxt = '0;
                    w_state_nxt   = PLL_RESET;
                end
            end
            FAULT: begin
                if (relock_req_i) begin
                    w_retries_nxt = '0;
                    w_state_nxt   = PLL_RESET;
                end
            end
            default: begin
                w_state_nxt = PLL_RESET;
            end
        endcase

        // The counter times only the bounded states; it is cleared on every
        // state change and idles at zero in RUN and FAULT so it never wraps.
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if (r_state == RUN || r_state == FAULT) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= PLL_RESET;
            r_cnt       <= '0;
            r_retries   <= '0;
            r_loss_cnt  <= '0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retries   <= w_retries_nxt;
            r_loss_cnt  <= w_loss_cnt_nxt;
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    assign pll_resetb_o = (r_state != PLL_RESET) && (r_state != FAULT);
    assign sys_reset_o  = (r_state != RUN);
    assign ready_o      = (r_state == RUN);
    assign fault_o      = (r_state == FAULT);
    assign lock_lost_o  = r_lock_lost;
    assign retries_o    = r_retries;
    assign loss_count_o = r_loss_cnt;

endmodule
`default_nettype wire
